mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter: ADDR_LIMIT, 512, byte count of the attached RAM; accesses ending at or beyond it are rejected.
REQ-002 SHALL provide parameter: TIMEOUT_CYCLES, 16, WAIT-state cycle budget for MOC (used only with MEM_ARB_TIMEOUT_EN).
REQ-003 SHALL have one clock; reset is asynchronous and active-low. Ports: Clk input 1 clock; Reset_n input 1 asynchronous active-low reset.
REQ-004 SHALL have ports: I_Req input 1, instruction-fetch request; I_Addr input 32, fetch byte address; I_Ack output 1, one-cycle completion pulse; I_Data output 32, fetched word; I_Err output 1, error qualifier valid with I_Ack.
REQ-005 SHALL have ports: D_Req input 1, data request; D_ReadWrite input 1, 1=read 0=write; D_OP input 6, load/store opcode; D_Addr input 32, byte address; D_WData input 32, store data; D_Ack output 1, completion pulse; D_RData output 32, load data; D_Err output 1, error qualifier valid with D_Ack.
REQ-006 SHALL have RAM-side ports: MOV output 1, memory operation valid; MemReadWrite output 1; MemAddress output 32; MemDataIn output 32; MemOP output 6; MOC input 1, memory operation complete; MemDataOut input 32; Busy output 1, high in any non-IDLE state.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; IDLE->ISSUE on any Req, ISSUE->WAIT unconditionally, WAIT->DONE on sampled MOC=1 (or timeout), DONE->IDLE unconditionally.
REQ-008 SHALL, in IDLE with both Req high, grant the port not granted last (round-robin); after reset D wins the first tie.
REQ-009 SHALL register MemAddress, MemReadWrite, MemOP, MemDataIn at grant and hold them stable through ISSUE and WAIT.
REQ-010 SHALL drive I-port accesses as reads with MemOP=100011 (word).
REQ-011 SHALL assert MOV in ISSUE and WAIT only; MOV is low in IDLE and DONE.
REQ-012 SHALL ignore MOC during ISSUE, so a stale MOC=1 left from a prior access cannot end the new one.
REQ-013 SHALL capture MemDataOut into the granted port's data output on the edge WAIT->DONE for reads; write completions leave D_RData unchanged.
REQ-014 SHALL pulse the granted port's Ack for exactly one cycle in DONE; minimum latency Req sampled at edge 0 -> Ack high after edge 3.
REQ-015 SHALL require requesters to hold Req and request fields stable until Ack; Req still high in the cycle after Ack is treated as a new request.
REQ-016 SHALL reject, without asserting MOV, any access with misalignment (word: Addr[1:0]!=0; halfword 100101/101001: Addr[0]!=0), Addr+size-1 >= ADDR_LIMIT, or D_OP not in {100011,100101,100100} for reads or {101011,101001,101000} for writes; the FSM goes IDLE->DONE with Err=1 and read data 0.
REQ-017 SHALL compute the range check in 33 bits so that addresses near 2^32 cannot wrap into range.
REQ-018 SHALL keep the non-granted port's Ack and Err low at all times.

Reset
REQ-019 SHALL on Reset_n low, including mid-access, force IDLE, MOV=0, all Acks/Errs/Busy=0, all data and Mem* outputs=0, round-robin pointer to D, and timeout counter 0.
REQ-020 SHALL not complete or acknowledge an aborted access after reset release; the requester re-issues it.

Configuration
REQ-021 SHALL, with MEM_ARB_TIMEOUT_EN defined, count WAIT cycles and on reaching TIMEOUT_CYCLES without MOC go to DONE with Err=1, read data 0, MOV dropped.
REQ-022 SHALL, without MEM_ARB_TIMEOUT_EN, wait in WAIT indefinitely for MOC, contain no counter logic, and never set Err for timeouts.

Verification
REQ-023 SHALL cover: D read OP=100011 Addr=0x10, RAM word 0xDEADBEEF, MOC 1 cycle after MOV -> D_Ack one cycle, D_RData=0xDEADBEEF, D_Err=0, latency 3.
REQ-024 SHALL cover: I_Req and D_Req both high from reset, repeated back-to-back -> grant order D,I,D,I; each Ack exactly one pulse.
REQ-025 SHALL cover: D write OP=101001 Addr=0x21 -> no MOV, D_Ack with D_Err=1 after 1 cycle; Addr=0x1FF word read -> D_Err=1.
REQ-026 SHALL cover: MOC held high from prior access, new read issued -> MOC ignored in ISSUE, data captured only after WAIT sample.
REQ-027 SHALL cover: Reset_n pulsed low during WAIT -> MOV=0 immediately, no Ack after release; with MEM_ARB_TIMEOUT_EN and MOC stuck low -> Err=1 after 16 WAIT cycles.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-fetch port, D-access port and RAM-side bus for mem_arbiter.
// master: arbiter view; slave: requesters plus RAM view.
interface mem_arbiter_if;
  logic        I_Req;
  logic [31:0] I_Addr;
  logic        I_Ack;
  logic [31:0] I_Data;
  logic        I_Err;

  logic        D_Req;
  logic        D_ReadWrite;
  logic [5:0]  D_OP;
  logic [31:0] D_Addr;
  logic [31:0] D_WData;
  logic        D_Ack;
  logic [31:0] D_RData;
  logic        D_Err;

  logic        MOV;
  logic        MemReadWrite;
  logic [31:0] MemAddress;
  logic [31:0] MemDataIn;
  logic [5:0]  MemOP;
  logic        MOC;
  logic [31:0] MemDataOut;
  logic        Busy;

  modport master (
    input  I_Req, I_Addr,
    output I_Ack, I_Data, I_Err,
    input  D_Req, D_ReadWrite, D_OP, D_Addr, D_WData,
    output D_Ack, D_RData, D_Err,
    output MOV, MemReadWrite, MemAddress, MemDataIn, MemOP, Busy,
    input  MOC, MemDataOut
  );

  modport slave (
    output I_Req, I_Addr,
    input  I_Ack, I_Data, I_Err,
    output D_Req, D_ReadWrite, D_OP, D_Addr, D_WData,
    input  D_Ack, D_RData, D_Err,
    input  MOV, MemReadWrite, MemAddress, MemDataIn, MemOP, Busy,
    output MOC, MemDataOut
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM between instruction-fetch and data ports.
// Define MEM_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles without MOC.
module mem_arbiter #(
  parameter int ADDR_LIMIT     = 512,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic   Clk,
  input  logic   Reset_n,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [32:0] LIMIT    = 33'(ADDR_LIMIT);
  localparam logic [5:0]  OP_WORD  = 6'b100011;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_reg, state_next;
  logic        gnt_d_reg;
  logic        prio_d_reg;
  logic        err_reg;
  logic [31:0] i_data_reg, d_rdata_reg;
  logic        mem_rw_reg;
  logic [31:0] mem_addr_reg, mem_wdata_reg;
  logic [5:0]  mem_op_reg;

  logic        take_d;
  logic        sel_rw;
  logic [5:0]  sel_op;
  logic [31:0] sel_addr;
  logic [1:0]  size_m1;
  logic [32:0] end_addr;
  logic        op_ok, misalign, reject;
  logic        grant, capture, expire;

  // On a tie the port holding priority wins; priority passes to the other port on every grant.
  assign take_d   = bus.D_Req && (!bus.I_Req || prio_d_reg);
  assign sel_rw   = take_d ? bus.D_ReadWrite : 1'b1;
  assign sel_op   = take_d ? bus.D_OP : OP_WORD;
  assign sel_addr = take_d ? bus.D_Addr : bus.I_Addr;

  always_comb begin
    op_ok    = 1'b0;
    size_m1  = 2'd0;
    misalign = 1'b0;
    case (sel_op)
      6'b100011, 6'b100101, 6'b100100: op_ok = sel_rw;
      6'b101011, 6'b101001, 6'b101000: op_ok = !sel_rw;
      default:                         op_ok = 1'b0;
    endcase
    case (sel_op[1:0])
      2'b11: begin size_m1 = 2'd3; misalign = (sel_addr[1:0] != 2'b00); end
      2'b01: begin size_m1 = 2'd1; misalign = sel_addr[0]; end
      default: begin size_m1 = 2'd0; misalign = 1'b0; end
    endcase
  end

  // 33-bit sum so an address near 2^32 cannot wrap back under the limit.
  assign end_addr = {1'b0, sel_addr} + {31'b0, size_m1};
  assign reject   = !op_ok || misalign || (end_addr >= LIMIT);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                wait_cnt_reg <= '0;
    else if (state_reg == WAIT)  wait_cnt_reg <= wait_cnt_reg + 1'b1;
    else                         wait_cnt_reg <= '0;
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.I_Req || bus.D_Req) begin
          grant      = 1'b1;
          state_next = reject ? DONE : ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (bus.MOC) begin
          capture    = 1'b1;
          state_next = DONE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
          expire     = 1'b1;
          state_next = DONE;
        end
`endif
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gnt_d_reg     <= 1'b0;
      prio_d_reg    <= 1'b1;
      err_reg       <= 1'b0;
      i_data_reg    <= '0;
      d_rdata_reg   <= '0;
      mem_rw_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_op_reg    <= '0;
    end else begin
      if (grant) begin
        gnt_d_reg  <= take_d;
        prio_d_reg <= !take_d;
        err_reg    <= reject;
        if (reject) begin
          if (take_d) d_rdata_reg <= '0;
          else        i_data_reg  <= '0;
        end else begin
          mem_rw_reg    <= sel_rw;
          mem_addr_reg  <= sel_addr;
          mem_op_reg    <= sel_op;
          mem_wdata_reg <= take_d ? bus.D_WData : 32'd0;
        end
      end
      // Write completions deliberately leave D_RData untouched.
      if ((capture || expire) && mem_rw_reg) begin
        if (gnt_d_reg) d_rdata_reg <= capture ? bus.MemDataOut : 32'd0;
        else           i_data_reg  <= capture ? bus.MemDataOut : 32'd0;
      end
      if (expire) err_reg <= 1'b1;
    end
  end

  assign bus.MOV          = (state_reg == ISSUE) || (state_reg == WAIT);
  assign bus.Busy         = (state_reg != IDLE);
  assign bus.MemReadWrite = mem_rw_reg;
  assign bus.MemAddress   = mem_addr_reg;
  assign bus.MemDataIn    = mem_wdata_reg;
  assign bus.MemOP        = mem_op_reg;
  assign bus.D_Ack        = (state_reg == DONE) && gnt_d_reg;
  assign bus.I_Ack        = (state_reg == DONE) && !gnt_d_reg;
  assign bus.D_Err        = bus.D_Ack && err_reg;
  assign bus.I_Err        = bus.I_Ack && err_reg;
  assign bus.D_RData      = d_rdata_reg;
  assign bus.I_Data       = i_data_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; build with +define+MEM_ARB_TIMEOUT_EN
// to exercise the WAIT timeout instead of the unbounded wait.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.ADDR_LIMIT(512), .TIMEOUT_CYCLES(16)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.I_Req = 0; bus.I_Addr = 0;
    bus.D_Req = 0; bus.D_ReadWrite = 0; bus.D_OP = 0; bus.D_Addr = 0; bus.D_WData = 0;
    bus.MOC = 0; bus.MemDataOut = 0;
  endtask

  // One access on one port; raises MOC moc_after cycles after MOV first appears.
  task automatic do_access(input bit use_d, input logic rw, input logic [5:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] ram_word, input int moc_after, input int limit,
                           output int lat, output logic err, output logic [31:0] rdata,
                           output int mov_cycles, output int acks,
                           output logic [31:0] m_addr, output logic [5:0] m_op,
                           output logic m_rw, output logic [31:0] m_wdata, output bit stable);
    lat = -1; err = 0; rdata = 0; mov_cycles = 0; acks = 0; stable = 1;
    m_addr = 0; m_op = 0; m_rw = 0; m_wdata = 0;
    if (use_d) begin
      bus.D_Req = 1; bus.D_ReadWrite = rw; bus.D_OP = op; bus.D_Addr = addr; bus.D_WData = wdata;
    end else begin
      bus.I_Req = 1; bus.I_Addr = addr;
    end
    for (int c = 1; c <= limit && lat < 0; c++) begin
      tick();
      if (bus.MOV) begin
        if (mov_cycles == 0) begin
          m_addr = bus.MemAddress; m_op = bus.MemOP; m_rw = bus.MemReadWrite; m_wdata = bus.MemDataIn;
        end else if (m_addr !== bus.MemAddress || m_op !== bus.MemOP ||
                     m_rw !== bus.MemReadWrite || m_wdata !== bus.MemDataIn) begin
          stable = 0;
        end
        mov_cycles++;
        if (mov_cycles == moc_after + 1) begin
          bus.MOC = 1; bus.MemDataOut = ram_word;
        end
      end
      if (use_d ? bus.D_Ack : bus.I_Ack) begin
        lat = c; acks++;
        err   = use_d ? bus.D_Err : bus.I_Err;
        rdata = use_d ? bus.D_RData : bus.I_Data;
      end
    end
    bus.D_Req = 0; bus.I_Req = 0; bus.MOC = 0;
    tick();
    if (use_d ? bus.D_Ack : bus.I_Ack) acks++;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    vectors++;
    if (bus.MOV !== 1'b0 || bus.Busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_mov_busy: got MOV=%b Busy=%b want 0 0", bus.MOV, bus.Busy);
    end
    vectors++;
    if ({bus.I_Ack, bus.D_Ack, bus.I_Err, bus.D_Err} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ack_err: got %b want 0000", {bus.I_Ack, bus.D_Ack, bus.I_Err, bus.D_Err});
    end
    vectors++;
    if (bus.I_Data !== 32'd0 || bus.D_RData !== 32'd0) begin
      miscompares++; $display("FAIL reset_data: got I=%h D=%h want 0", bus.I_Data, bus.D_RData);
    end
    vectors++;
    if (bus.MemAddress !== 32'd0 || bus.MemDataIn !== 32'd0 || bus.MemOP !== 6'd0 || bus.MemReadWrite !== 1'b0) begin
      miscompares++; $display("FAIL reset_mem: got A=%h DI=%h OP=%b RW=%b want 0", bus.MemAddress, bus.MemDataIn, bus.MemOP, bus.MemReadWrite);
    end
    rst_n = 1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    string order = "";
    int    nacks = 0;
    logic  prev_d = 0, prev_i = 0;
    bit    overlap = 0, long_pulse = 0;
    logic [31:0] i_got = 0;
    idle_inputs();
    rst_n = 0;
    bus.I_Req = 1; bus.I_Addr = 32'h100;
    bus.D_Req = 1; bus.D_ReadWrite = 1; bus.D_OP = 6'b100011; bus.D_Addr = 32'h20;
    tick();
    rst_n = 1;
    for (int c = 0; c < 60 && nacks < 4; c++) begin
      tick();
      if (bus.D_Ack && bus.I_Ack) overlap = 1;
      if ((bus.D_Ack && prev_d) || (bus.I_Ack && prev_i)) long_pulse = 1;
      if (bus.D_Ack) begin order = {order, "D"}; nacks++; end
      if (bus.I_Ack) begin order = {order, "I"}; nacks++; i_got = bus.I_Data; end
      prev_d = bus.D_Ack; prev_i = bus.I_Ack;
      bus.MOC = bus.MOV;
      bus.MemDataOut = bus.MemAddress ^ 32'hA5A5_0000;
    end
    bus.I_Req = 0; bus.D_Req = 0; bus.MOC = 0;
    tick(); tick();
    vectors++;
    if (order != "DIDI") begin
      miscompares++; $display("FAIL rr_order: got '%s' want 'DIDI'", order);
    end
    vectors++;
    if (overlap || long_pulse) begin
      miscompares++; $display("FAIL rr_pulse: overlap=%0d long=%0d want 0 0", overlap, long_pulse);
    end
    vectors++;
    if (i_got !== 32'hA5A5_0100) begin
      miscompares++; $display("FAIL rr_idata: got %h want a5a50100", i_got);
    end
    $display("test_back_to_back order=%s", order);
  endtask

  task automatic test_d_read();
    int lat, mov, acks; logic err, m_rw; logic [31:0] rd, m_a, m_wd; logic [5:0] m_op; bit st;
    do_access(1, 1, 6'b100011, 32'h10, 32'h0, 32'hDEADBEEF, 1, 20,
              lat, err, rd, mov, acks, m_a, m_op, m_rw, m_wd, st);
    vectors++;
    if (lat !== 3 || acks !== 1) begin
      miscompares++; $display("FAIL d_read_latency: got lat=%0d acks=%0d want 3 1", lat, acks);
    end
    vectors++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
      miscompares++; $display("FAIL d_read_data: got %h err=%b want deadbeef 0", rd, err);
    end
    vectors++;
    if (m_a !== 32'h10 || m_rw !== 1'b1 || m_op !== 6'b100011 || !st || mov !== 2) begin
      miscompares++; $display("FAIL d_read_bus: got A=%h RW=%b OP=%b stable=%0d mov=%0d want 10 1 100011 1 2", m_a, m_rw, m_op, st, mov);
    end
    $display("test_d_read lat=%0d data=%h", lat, rd);
  endtask

  task automatic test_d_write();
    int lat, mov, acks; logic err, m_rw; logic [31:0] rd, m_a, m_wd; logic [5:0] m_op; bit st;
    do_access(1, 0, 6'b101011, 32'h40, 32'hCAFEF00D, 32'h12345678, 1, 20,
              lat, err, rd, mov, acks, m_a, m_op, m_rw, m_wd, st);
    vectors++;
    if (lat !== 3 || err !== 1'b0 || acks !== 1) begin
      miscompares++; $display("FAIL d_write_ack: got lat=%0d err=%b acks=%0d want 3 0 1", lat, err, acks);
    end
    vectors++;
    if (m_rw !== 1'b0 || m_wd !== 32'hCAFEF00D || m_op !== 6'b101011 || m_a !== 32'h40 || !st) begin
      miscompares++; $display("FAIL d_write_bus: got RW=%b DI=%h OP=%b A=%h stable=%0d want 0 cafef00d 101011 40 1", m_rw, m_wd, m_op, m_a, st);
    end
    vectors++;
    if (rd !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL d_write_rdata_kept: got %h want deadbeef", rd);
    end
    $display("test_d_write lat=%0d", lat);
  endtask

  task automatic test_i_fetch();
    int lat, mov, acks; logic err, m_rw; logic [31:0] rd, m_a, m_wd; logic [5:0] m_op; bit st;
    do_access(0, 1, 6'b000000, 32'h80, 32'h0, 32'h0BADC0DE, 2, 20,
              lat, err, rd, mov, acks, m_a, m_op, m_rw, m_wd, st);
    vectors++;
    if (lat !== 4 || err !== 1'b0 || rd !== 32'h0BADC0DE || acks !== 1) begin
      miscompares++; $display("FAIL i_fetch: got lat=%0d err=%b data=%h acks=%0d want 4 0 0badc0de 1", lat, err, rd, acks);
    end
    vectors++;
    if (m_op !== 6'b100011 || m_rw !== 1'b1 || m_a !== 32'h80) begin
      miscompares++; $display("FAIL i_fetch_bus: got OP=%b RW=%b A=%h want 100011 1 80", m_op, m_rw, m_a);
    end
    $display("test_i_fetch lat=%0d data=%h", lat, rd);
  endtask

  typedef struct {logic rw; logic [5:0] op; logic [31:0] addr; logic exp_err;} chk_t;

  task automatic test_boundaries();
    chk_t tbl[8];
    tbl[0] = '{1'b0, 6'b101001, 32'h0000_0021, 1'b1}; // misaligned halfword store
    tbl[1] = '{1'b1, 6'b100011, 32'h0000_01FF, 1'b1}; // misaligned and out of range
    tbl[2] = '{1'b1, 6'b100011, 32'h0000_01FC, 1'b0}; // last legal word
    tbl[3] = '{1'b1, 6'b100101, 32'h0000_01FE, 1'b0};
    tbl[4] = '{1'b1, 6'b100100, 32'h0000_01FF, 1'b0};
    tbl[5] = '{1'b1, 6'b100011, 32'h0000_0200, 1'b1};
    tbl[6] = '{1'b1, 6'b101011, 32'h0000_0010, 1'b1}; // store opcode on a read
    tbl[7] = '{1'b1, 6'b100011, 32'hFFFF_FFFC, 1'b1};
    foreach (tbl[k]) begin
      int lat, mov, acks; logic err, m_rw; logic [31:0] rd, m_a, m_wd; logic [5:0] m_op; bit st;
      logic [31:0] word;
      word = 32'h5000_0000 + k;
      do_access(1, tbl[k].rw, tbl[k].op, tbl[k].addr, 32'h0, word, 1, 20,
                lat, err, rd, mov, acks, m_a, m_op, m_rw, m_wd, st);
      vectors++;
      if (err !== tbl[k].exp_err || lat !== (tbl[k].exp_err ? 1 : 3) ||
          mov !== (tbl[k].exp_err ? 0 : 2) || acks !== 1) begin
        miscompares++;
        $display("FAIL bound_%0d: got err=%b lat=%0d mov=%0d acks=%0d want err=%b", k, err, lat, mov, acks, tbl[k].exp_err);
      end
      if (tbl[k].rw) begin
        vectors++;
        if (rd !== (tbl[k].exp_err ? 32'd0 : word)) begin
          miscompares++; $display("FAIL bound_%0d_data: got %h want %h", k, rd, tbl[k].exp_err ? 32'd0 : word);
        end
      end
      $display("bound %0d addr=%h op=%b err=%b lat=%0d", k, tbl[k].addr, tbl[k].op, err, lat);
    end
  endtask

  task automatic test_stale_moc();
    logic ack_early;
    bus.MOC = 1; bus.MemDataOut = 32'h1111_1111;
    bus.D_Req = 1; bus.D_ReadWrite = 1; bus.D_OP = 6'b100011; bus.D_Addr = 32'h44;
    tick();
    tick();
    ack_early = bus.D_Ack;
    bus.MemDataOut = 32'h2222_2222;
    tick();
    vectors++;
    if (ack_early !== 1'b0 || bus.D_Ack !== 1'b1) begin
      miscompares++; $display("FAIL stale_moc_ack: got early=%b at3=%b want 0 1", ack_early, bus.D_Ack);
    end
    vectors++;
    if (bus.D_RData !== 32'h2222_2222) begin
      miscompares++; $display("FAIL stale_moc_data: got %h want 22222222", bus.D_RData);
    end
    bus.D_Req = 0; bus.MOC = 0;
    tick();
    $display("test_stale_moc data=%h", bus.D_RData);
  endtask

  task automatic test_reset_mid_wait();
    bit ack_seen = 0;
    logic mov_before;
    bus.D_Req = 1; bus.D_ReadWrite = 1; bus.D_OP = 6'b100011; bus.D_Addr = 32'h30;
    tick(); tick();
    mov_before = bus.MOV;
    rst_n = 0;
    #1;
    vectors++;
    if (mov_before !== 1'b1 || bus.MOV !== 1'b0 || bus.Busy !== 1'b0 || bus.MemAddress !== 32'd0 || bus.D_RData !== 32'd0) begin
      miscompares++; $display("FAIL reset_wait: got MOVbefore=%b MOV=%b Busy=%b A=%h RD=%h want 1 0 0 0 0", mov_before, bus.MOV, bus.Busy, bus.MemAddress, bus.D_RData);
    end
    bus.D_Req = 0;
    tick();
    rst_n = 1;
    bus.MOC = 1; bus.MemDataOut = 32'h7777_7777;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.D_Ack || bus.I_Ack || bus.MOV) ack_seen = 1;
    end
    bus.MOC = 0;
    vectors++;
    if (ack_seen) begin
      miscompares++; $display("FAIL reset_no_ack: got activity after release want none");
    end
    $display("test_reset_mid_wait done");
  endtask

  task automatic test_long_wait();
    int lat, mov, acks; logic err, m_rw; logic [31:0] rd, m_a, m_wd; logic [5:0] m_op; bit st;
    do_access(1, 1, 6'b100011, 32'h60, 32'h0, 32'h3C3C_3C3C, 30, 60,
              lat, err, rd, mov, acks, m_a, m_op, m_rw, m_wd, st);
`ifdef MEM_ARB_TIMEOUT_EN
    vectors++;
    if (lat !== 18 || err !== 1'b1 || rd !== 32'd0 || mov !== 17 || acks !== 1) begin
      miscompares++; $display("FAIL timeout: got lat=%0d err=%b data=%h mov=%0d acks=%0d want 18 1 0 17 1", lat, err, rd, mov, acks);
    end
`else
    vectors++;
    if (lat !== 32 || err !== 1'b0 || rd !== 32'h3C3C_3C3C || acks !== 1) begin
      miscompares++; $display("FAIL long_wait: got lat=%0d err=%b data=%h acks=%0d want 32 0 3c3c3c3c 1", lat, err, rd, acks);
    end
`endif
    $display("test_long_wait lat=%0d err=%b", lat, err);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_reset();
    test_d_read();
    test_d_write();
    test_i_fetch();
    test_boundaries();
    test_stale_moc();
    test_long_wait();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
